// File: rtl/uart_tx_param_if.sv
// Byte-stream handshake and serial-line bundle between a byte producer and uart_tx_param.
interface uart_tx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 tx_dv;
    logic [DATA_BITS-1:0] tx_byte;
    logic                 tx_ready;
    logic                 tx_active;
    logic                 tx_serial;
    logic                 tx_done;

    modport master (
        output tx_dv,
        output tx_byte,
        input  tx_ready,
        input  tx_active,
        input  tx_serial,
        input  tx_done
    );

    modport slave (
        input  tx_dv,
        input  tx_byte,
        output tx_ready,
        output tx_active,
        output tx_serial,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: configurable width/parity/stop bits, one-entry holding
// register so a queued byte starts immediately after the previous frame's last stop cycle.
module uart_tx_param #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic           i_Clock,
    input  logic           i_Rst_n,
    uart_tx_param_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam bit PARAMS_OK = (CLKS_PER_BIT >= 2) && (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
                               (PARITY_MODE <= 2) && ((STOP_BITS == 1) || (STOP_BITS == 2));

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 ready_q, ready_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;
    logic                 load;
    logic                 cnt_last;
    logic                 idx_last;

    assign cnt_last = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign idx_last = (idx_q == IDX_W'(DATA_BITS - 1));

    // Next-state and next-output logic; registered below.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        stop_d      = stop_q;
        shift_d     = shift_q;
        par_d       = par_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        serial_d    = serial_q;
        active_d    = active_q;
        done_d      = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: load = hold_full_q;
            START: begin
                if (cnt_last) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = shift_q[0];
                    state_d  = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (!cnt_last) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!idx_last) begin
                    cnt_d    = '0;
                    idx_d    = idx_q + 1'b1;
                    shift_d  = shift_q >> 1;
                    serial_d = shift_q[1];
                end else if (PARITY_MODE != 0) begin
                    cnt_d    = '0;
                    serial_d = par_q;
                    state_d  = PARITY;
                end else begin
                    cnt_d    = '0;
                    stop_d   = 1'b0;
                    serial_d = 1'b1;
                    state_d  = STOP;
                end
            end
            PARITY: begin
                if (cnt_last) begin
                    cnt_d    = '0;
                    stop_d   = 1'b0;
                    serial_d = 1'b1;
                    state_d  = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (!cnt_last) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (stop_q != 1'(STOP_BITS - 1)) begin
                    cnt_d  = '0;
                    stop_d = 1'b1;
                end else begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        active_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Holding register to shift register; line falls on the same edge.
        if (load) begin
            shift_d     = hold_q;
            par_d       = (^hold_q) ^ (PARITY_MODE == 1);
            hold_full_d = 1'b0;
            cnt_d       = '0;
            serial_d    = 1'b0;
            active_d    = 1'b1;
            state_d     = START;
        end

        if (bus.tx_dv && ready_q) begin
            hold_d      = bus.tx_byte;
            hold_full_d = 1'b1;
        end

        ready_d = !hold_full_d;
    end

    always_ff @(posedge i_Clock) begin
        assert (PARAMS_OK) else $error("uart_tx_param: unsupported parameter set");
        if (!i_Rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            stop_q      <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            serial_q    <= 1'b1;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stop_q      <= stop_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            serial_q    <= serial_d;
            active_q    <= active_d;
            done_q      <= done_d;
        end
    end

    assign bus.tx_ready  = ready_q;
    assign bus.tx_active = active_q;
    assign bus.tx_serial = serial_q;
    assign bus.tx_done   = done_q;
endmodule
